// File: rtl/xocc_hub_pkg.sv
// Shared constants and sizing helpers for the XOCC channel hub.
// Slice helpers locate a channel inside the flattened DSA-side buses.
package xocc_hub_pkg;

  localparam int XOCC_WORD_W = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_ch_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  function automatic int cmd_slice_lo(input int ch, input int cmd_words);
    return ch * XOCC_WORD_W * cmd_words;
  endfunction

  function automatic int rsp_slice_lo(input int ch);
    return ch * XOCC_WORD_W;
  endfunction

endpackage

// File: rtl/xocc_sync_fifo.sv
// Count-based show-ahead FIFO with registered full/empty flags.
// Push while full and pop while empty are ignored; storage is not reset.
module xocc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/xocc_chan_hub.sv
// N-channel XOCC hub: CPU words are packed into commands per channel and queued
// to the DSA; DSA responses are queued back to the CPU, with sticky error flags.
module xocc_chan_hub
  import xocc_hub_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CMD_WORDS = 3,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  localparam int CH_W     = calc_ch_w(NUM_CH)
) (
  input  logic                                i_pad_clk,
  input  logic                                i_pad_rst,
  input  logic                                cpu_cmd_valid,
  output logic                                cpu_cmd_ready,
  input  logic [CH_W-1:0]                     cpu_cmd_chan,
  input  logic [XOCC_WORD_W-1:0]              cpu_cmd_data,
  input  logic [CH_W-1:0]                     cpu_rsp_chan,
  output logic                                cpu_rsp_valid,
  input  logic                                cpu_rsp_ready,
  output logic [XOCC_WORD_W-1:0]              cpu_rsp_data,
  output logic [NUM_CH*XOCC_WORD_W*CMD_WORDS-1:0] xocc_cmd_buffer,
  output logic [NUM_CH-1:0]                   xocc_cmd_empty,
  input  logic [NUM_CH-1:0]                   xocc_cmd_rd_en,
  input  logic [NUM_CH*XOCC_WORD_W-1:0]       xocc_rsp_buffer,
  input  logic [NUM_CH-1:0]                   xocc_rsp_wr_en,
  output logic [NUM_CH-1:0]                   xocc_rsp_full,
  output logic [NUM_CH-1:0]                   err_cmd_udf,
  output logic [NUM_CH-1:0]                   err_rsp_ovf,
  input  logic [NUM_CH-1:0]                   err_clr
);

  localparam int CMD_W = XOCC_WORD_W * CMD_WORDS;
  localparam int CNT_W = clog2_min1(CMD_WORDS);

  logic [NUM_CH-1:0]      word_acc, cmd_final, cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [NUM_CH-1:0]      rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [CMD_W-1:0]       cmd_push_data [NUM_CH];
  logic [CMD_W-1:0]       cmd_head      [NUM_CH];
  logic [XOCC_WORD_W-1:0] rsp_head      [NUM_CH];
  logic                   cmd_stall;
  logic                   rsp_sel_valid;
  logic [XOCC_WORD_W-1:0] rsp_sel_data;

  // Only a final word into a full command FIFO stalls; the flag is registered.
  always_comb begin
    cmd_stall     = 1'b0;
    rsp_sel_valid = 1'b0;
    rsp_sel_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cpu_cmd_chan == CH_W'(c) && cmd_final[c] && cmd_full[c]) cmd_stall = 1'b1;
      if (cpu_rsp_chan == CH_W'(c)) begin
        rsp_sel_valid = !rsp_empty[c];
        rsp_sel_data  = rsp_head[c];
      end
    end
  end

  assign cpu_cmd_ready = !i_pad_rst && !cmd_stall;
  assign cpu_rsp_valid = !i_pad_rst && rsp_sel_valid;
  assign cpu_rsp_data  = rsp_sel_data;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
    localparam int CMD_LO = cmd_slice_lo(gi, CMD_WORDS);
    localparam int RSP_LO = rsp_slice_lo(gi);

    logic udf_q, udf_d;
    logic ovf_q, ovf_d;

    assign word_acc[gi] = cpu_cmd_valid && cpu_cmd_ready && (cpu_cmd_chan == CH_W'(gi));

    if (CMD_WORDS > 1) begin : pack_g
      logic [CNT_W-1:0]                     cnt_q, cnt_d;
      logic [XOCC_WORD_W*(CMD_WORDS-1)-1:0] stage_q, stage_d;

      always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (word_acc[gi]) begin
          if (cmd_final[gi]) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            stage_d[cnt_q*XOCC_WORD_W +: XOCC_WORD_W] = cpu_cmd_data;
          end
        end
      end

      always_ff @(posedge i_pad_clk) begin
        if (i_pad_rst) cnt_q <= '0;
        else           cnt_q <= cnt_d;
      end

      always_ff @(posedge i_pad_clk) begin
        stage_q <= stage_d;
      end

      assign cmd_final[gi]     = (cnt_q == CNT_W'(CMD_WORDS - 1));
      assign cmd_push_data[gi] = {cpu_cmd_data, stage_q};
    end else begin : direct_g
      assign cmd_final[gi]     = 1'b1;
      assign cmd_push_data[gi] = cpu_cmd_data;
    end

    assign cmd_push[gi] = word_acc[gi] && cmd_final[gi];
    assign cmd_pop[gi]  = xocc_cmd_rd_en[gi] && !cmd_empty[gi];
    assign rsp_push[gi] = xocc_rsp_wr_en[gi] && !rsp_full[gi];
    assign rsp_pop[gi]  = cpu_rsp_valid && cpu_rsp_ready && (cpu_rsp_chan == CH_W'(gi));

    // A new error event outranks a simultaneous clear.
    always_comb begin
      udf_d = (udf_q && !err_clr[gi]) || (xocc_cmd_rd_en[gi] && cmd_empty[gi]);
      ovf_d = (ovf_q && !err_clr[gi]) || (xocc_rsp_wr_en[gi] && rsp_full[gi]);
    end

    always_ff @(posedge i_pad_clk) begin
      if (i_pad_rst) begin
        udf_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        udf_q <= udf_d;
        ovf_q <= ovf_d;
      end
    end

    xocc_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk       (i_pad_clk),
      .srst      (i_pad_rst),
      .push      (cmd_push[gi]),
      .push_data (cmd_push_data[gi]),
      .pop       (cmd_pop[gi]),
      .full      (cmd_full[gi]),
      .empty     (cmd_empty[gi]),
      .head      (cmd_head[gi])
    );

    xocc_sync_fifo #(.WIDTH(XOCC_WORD_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (i_pad_clk),
      .srst      (i_pad_rst),
      .push      (rsp_push[gi]),
      .push_data (xocc_rsp_buffer[RSP_LO +: XOCC_WORD_W]),
      .pop       (rsp_pop[gi]),
      .full      (rsp_full[gi]),
      .empty     (rsp_empty[gi]),
      .head      (rsp_head[gi])
    );

    assign xocc_cmd_buffer[CMD_LO +: CMD_W] = cmd_head[gi];
    assign xocc_cmd_empty[gi] = cmd_empty[gi];
    assign xocc_rsp_full[gi]  = rsp_full[gi];
    assign err_cmd_udf[gi]    = udf_q;
    assign err_rsp_ovf[gi]    = ovf_q;
  end

endmodule

// File: tb/tb_xocc_chan_hub.sv
// Directed plus randomized bench for xocc_chan_hub; a queue-based model of the
// channel behaviour predicts every output one cycle at a time.
module tb_xocc_chan_hub;

  localparam int NUM_CH    = 2;
  localparam int CMD_WORDS = 3;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int CH_W      = 1;
  localparam int CMD_W     = 32 * CMD_WORDS;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cpu_cmd_valid;
  logic                     cpu_cmd_ready;
  logic [CH_W-1:0]          cpu_cmd_chan;
  logic [31:0]              cpu_cmd_data;
  logic [CH_W-1:0]          cpu_rsp_chan;
  logic                     cpu_rsp_valid;
  logic                     cpu_rsp_ready;
  logic [31:0]              cpu_rsp_data;
  logic [NUM_CH*CMD_W-1:0]  xocc_cmd_buffer;
  logic [NUM_CH-1:0]        xocc_cmd_empty;
  logic [NUM_CH-1:0]        xocc_cmd_rd_en;
  logic [NUM_CH*32-1:0]     xocc_rsp_buffer;
  logic [NUM_CH-1:0]        xocc_rsp_wr_en;
  logic [NUM_CH-1:0]        xocc_rsp_full;
  logic [NUM_CH-1:0]        err_cmd_udf;
  logic [NUM_CH-1:0]        err_rsp_ovf;
  logic [NUM_CH-1:0]        err_clr;

  always #5 clk = ~clk;

  xocc_chan_hub #(
    .NUM_CH(NUM_CH), .CMD_WORDS(CMD_WORDS), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .i_pad_clk       (clk),
    .i_pad_rst       (rst),
    .cpu_cmd_valid   (cpu_cmd_valid),
    .cpu_cmd_ready   (cpu_cmd_ready),
    .cpu_cmd_chan    (cpu_cmd_chan),
    .cpu_cmd_data    (cpu_cmd_data),
    .cpu_rsp_chan    (cpu_rsp_chan),
    .cpu_rsp_valid   (cpu_rsp_valid),
    .cpu_rsp_ready   (cpu_rsp_ready),
    .cpu_rsp_data    (cpu_rsp_data),
    .xocc_cmd_buffer (xocc_cmd_buffer),
    .xocc_cmd_empty  (xocc_cmd_empty),
    .xocc_cmd_rd_en  (xocc_cmd_rd_en),
    .xocc_rsp_buffer (xocc_rsp_buffer),
    .xocc_rsp_wr_en  (xocc_rsp_wr_en),
    .xocc_rsp_full   (xocc_rsp_full),
    .err_cmd_udf     (err_cmd_udf),
    .err_rsp_ovf     (err_rsp_ovf),
    .err_clr         (err_clr)
  );

  // Reference model: queued commands, words collected toward the next command,
  // queued responses and sticky error bits per channel.
  logic [CMD_W-1:0] m_cmd  [NUM_CH][$];
  logic [31:0]      m_pend [NUM_CH][$];
  logic [31:0]      m_rsp  [NUM_CH][$];
  logic [NUM_CH-1:0] m_udf, m_ovf;
  bit               model_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    int ch;
    ch = int'(cpu_cmd_chan);
    if (rst) return 1'b0;
    if (!model_ok) return 1'b1;
    return !((m_pend[ch].size() == CMD_WORDS - 1) && (m_cmd[ch].size() == CMD_DEPTH));
  endfunction

  function automatic logic exp_rsp_valid();
    int ch;
    ch = int'(cpu_rsp_chan);
    return !rst && model_ok && (m_rsp[ch].size() > 0);
  endfunction

  task automatic check_outputs();
    logic v;
    chk("cmd_ready", cpu_cmd_ready, exp_ready());
    if (!model_ok) return;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("cmd_empty[%0d]", c), xocc_cmd_empty[c], m_cmd[c].size() == 0);
      if (m_cmd[c].size() > 0)
        chk($sformatf("cmd_buffer[%0d]", c), xocc_cmd_buffer[c*CMD_W +: CMD_W], m_cmd[c][0]);
      chk($sformatf("rsp_full[%0d]", c), xocc_rsp_full[c], m_rsp[c].size() == RSP_DEPTH);
      chk($sformatf("err_udf[%0d]", c), err_cmd_udf[c], m_udf[c]);
      chk($sformatf("err_ovf[%0d]", c), err_rsp_ovf[c], m_ovf[c]);
    end
    v = exp_rsp_valid();
    chk("rsp_valid", cpu_rsp_valid, v);
    if (v) chk("rsp_data", cpu_rsp_data, m_rsp[int'(cpu_rsp_chan)][0]);
  endtask

  task automatic model_step();
    logic rdy, rv, udf_set, ovf_set;
    logic [CMD_W-1:0] cmd;
    int ch;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cmd[c].delete();
        m_pend[c].delete();
        m_rsp[c].delete();
      end
      m_udf = '0;
      m_ovf = '0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    rdy = exp_ready();
    rv  = exp_rsp_valid();
    for (int c = 0; c < NUM_CH; c++) begin
      udf_set = xocc_cmd_rd_en[c] && (m_cmd[c].size() == 0);
      ovf_set = xocc_rsp_wr_en[c] && (m_rsp[c].size() == RSP_DEPTH);
      if (xocc_cmd_rd_en[c] && m_cmd[c].size() > 0) void'(m_cmd[c].pop_front());
      if (rv && cpu_rsp_ready && int'(cpu_rsp_chan) == c) void'(m_rsp[c].pop_front());
      if (xocc_rsp_wr_en[c] && !ovf_set) m_rsp[c].push_back(xocc_rsp_buffer[c*32 +: 32]);
      m_udf[c] = (m_udf[c] && !err_clr[c]) || udf_set;
      m_ovf[c] = (m_ovf[c] && !err_clr[c]) || ovf_set;
    end
    ch = int'(cpu_cmd_chan);
    if (cpu_cmd_valid && rdy) begin
      m_pend[ch].push_back(cpu_cmd_data);
      if (m_pend[ch].size() == CMD_WORDS) begin
        cmd = '0;
        for (int k = 0; k < CMD_WORDS; k++) cmd[k*32 +: 32] = m_pend[ch][k];
        m_cmd[ch].push_back(cmd);
        m_pend[ch].delete();
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 ns later.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_cmd_valid   = 1'b0;
    cpu_cmd_chan    = '0;
    cpu_cmd_data    = '0;
    cpu_rsp_chan    = '0;
    cpu_rsp_ready   = 1'b0;
    xocc_cmd_rd_en  = '0;
    xocc_rsp_buffer = '0;
    xocc_rsp_wr_en  = '0;
    err_clr         = '0;
  endtask

  task automatic send_word(input int ch, input logic [31:0] data);
    cpu_cmd_valid = 1'b1;
    cpu_cmd_chan  = CH_W'(ch);
    cpu_cmd_data  = data;
    cycle();
    cpu_cmd_valid = 1'b0;
  endtask

  logic [31:0] got [$];

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("reset cmd_empty", xocc_cmd_empty, 2'b11);
    chk("reset rsp_full", xocc_rsp_full, 2'b00);
    chk("reset err_udf", err_cmd_udf, 2'b00);
    chk("reset err_ovf", err_rsp_ovf, 2'b00);
    chk("reset rsp_valid", cpu_rsp_valid, 1'b0);
    chk("reset cmd_ready", cpu_cmd_ready, 1'b1);

    // Pack and drain on channel 1.
    send_word(1, 32'h11);
    send_word(1, 32'h22);
    send_word(1, 32'h33);
    chk("pack cmd_empty", xocc_cmd_empty, 2'b01);
    chk("pack slice1", xocc_cmd_buffer[CMD_W +: CMD_W], 96'h00000033_00000022_00000011);
    xocc_cmd_rd_en = 2'b10;
    cycle();
    xocc_cmd_rd_en = 2'b00;
    chk("drain cmd_empty", xocc_cmd_empty, 2'b11);

    // Interleaved packing on both channels.
    send_word(0, 32'hA0);
    send_word(1, 32'hB0);
    send_word(0, 32'hA1);
    send_word(1, 32'hB1);
    send_word(0, 32'hA2);
    send_word(1, 32'hB2);
    chk("ilv slice0", xocc_cmd_buffer[0 +: CMD_W], 96'h000000A2_000000A1_000000A0);
    chk("ilv slice1", xocc_cmd_buffer[CMD_W +: CMD_W], 96'h000000B2_000000B1_000000B0);
    xocc_cmd_rd_en = 2'b11;
    cycle();
    xocc_cmd_rd_en = 2'b00;

    // Command FIFO full: final word stalls until a pop.
    for (int n = 0; n < 4 * CMD_WORDS; n++) send_word(0, 32'h100 + n);
    send_word(0, 32'h200);
    send_word(0, 32'h201);
    cpu_cmd_valid = 1'b1;
    cpu_cmd_chan  = 1'b0;
    cpu_cmd_data  = 32'h202;
    #1;
    chk("full stall ready", cpu_cmd_ready, 1'b0);
    cycle();
    cycle();
    xocc_cmd_rd_en = 2'b01;
    #1;
    chk("pop same-cycle ready", cpu_cmd_ready, 1'b0);
    cycle();
    xocc_cmd_rd_en = 2'b00;
    #1;
    chk("after pop ready", cpu_cmd_ready, 1'b1);
    cycle();
    cpu_cmd_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      xocc_cmd_rd_en = 2'b01;
      cycle();
    end
    chk("full last cmd", xocc_cmd_buffer[0 +: CMD_W], 96'h00000202_00000201_00000200);
    cycle();
    xocc_cmd_rd_en = 2'b00;
    chk("full drained", xocc_cmd_empty, 2'b11);

    // Response overflow, CPU reads, underflow and clear.
    for (int n = 0; n < 5; n++) begin
      xocc_rsp_wr_en  = 2'b01;
      xocc_rsp_buffer = {32'h0, 32'hA0 + n};
      cycle();
    end
    xocc_rsp_wr_en = 2'b00;
    chk("ovf set", err_rsp_ovf, 2'b01);
    cpu_rsp_chan  = 1'b0;
    cpu_rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (cpu_rsp_valid) got.push_back(cpu_rsp_data);
      cycle();
    end
    cpu_rsp_ready = 1'b0;
    chk("rsp read count", got.size(), 4);
    for (int n = 0; n < got.size(); n++) chk($sformatf("rsp read %0d", n), got[n], 32'hA0 + n);
    xocc_cmd_rd_en = 2'b10;
    cycle();
    xocc_cmd_rd_en = 2'b00;
    chk("udf set", err_cmd_udf, 2'b10);
    err_clr = 2'b11;
    cycle();
    err_clr = 2'b00;
    chk("clr udf", err_cmd_udf, 2'b00);
    chk("clr ovf", err_rsp_ovf, 2'b00);

    // Reset mid-command discards the partial command.
    send_word(0, 32'hDEAD0);
    send_word(0, 32'hDEAD1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    send_word(0, 32'hC0);
    send_word(0, 32'hC1);
    send_word(0, 32'hC2);
    chk("rst cmd_empty", xocc_cmd_empty, 2'b10);
    chk("rst slice0", xocc_cmd_buffer[0 +: CMD_W], 96'h000000C2_000000C1_000000C0);
    xocc_cmd_rd_en = 2'b01;
    cycle();
    xocc_cmd_rd_en = 2'b00;
    chk("rst one cmd", xocc_cmd_empty, 2'b11);

    // Randomized traffic: a fill-biased phase then a drain-biased phase.
    for (int n = 0; n < 600; n++) begin
      bit fill;
      fill = (n < 300);
      cpu_cmd_valid   = ($urandom_range(0, 9) < 7);
      cpu_cmd_chan    = CH_W'($urandom_range(0, NUM_CH - 1));
      cpu_cmd_data    = $urandom;
      cpu_rsp_chan    = CH_W'($urandom_range(0, NUM_CH - 1));
      cpu_rsp_ready   = fill ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      xocc_rsp_buffer = {$urandom, $urandom};
      for (int c = 0; c < NUM_CH; c++) begin
        xocc_cmd_rd_en[c] = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        xocc_rsp_wr_en[c] = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
        err_clr[c]        = ($urandom_range(0, 15) == 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
